// File: rtl/wb_exc_commit_pkg.sv
// wb_exc_commit_pkg: shared constants, csr_ctrl layout and FSM encoding for the WB commit unit
package wb_exc_commit_pkg;
   localparam int WB2CSR_LEN   = 81;
   localparam int CSR_CTRL_LEN = 80;
   localparam logic [5:0] ECODE_INT = 6'h0;
   localparam logic [5:0] ECODE_ADE = 6'h8;
   localparam logic [5:0] ECODE_ALE = 6'h9;
   localparam logic [5:0] ECODE_SYS = 6'hB;
   localparam logic [5:0] ECODE_BRK = 6'hC;
   localparam logic [5:0] ECODE_INE = 6'hD;
   localparam logic [8:0] ESUBCODE_ADEF = 9'h0;
   // csr_ctrl = {csr_num[13:0], re, we, wvalue[31:0], wmask[31:0]}
   localparam int CSR_NUM_LSB    = 66;
   localparam int CSR_RE_BIT     = 65;
   localparam int CSR_WE_BIT     = 64;
   localparam int CSR_WVALUE_LSB = 32;
   localparam int CSR_WMASK_LSB  = 0;
   // in_exc = {adef, ine, sys, brk, ale}
   localparam int EXC_ADEF = 4;
   localparam int EXC_INE  = 3;
   localparam int EXC_SYS  = 2;
   localparam int EXC_BRK  = 1;
   localparam int EXC_ALE  = 0;
   typedef enum logic {S_RUN = 1'b0, S_FLUSH_WAIT = 1'b1} state_t;
endpackage

// File: rtl/wb_exc_commit_exc_prio_enc.sv
// exc_prio_enc: picks the highest-priority cause among the interrupt and upstream exception flags
module exc_prio_enc
   import wb_exc_commit_pkg::*;
(
   input  logic       has_int,
   input  logic [4:0] exc_flags,
   output logic       exc,
   output logic [5:0] ecode,
   output logic [8:0] esubcode
);
   always_comb begin
      exc      = has_int | (|exc_flags);
      ecode    = has_int                ? ECODE_INT :
                 exc_flags[EXC_ADEF]    ? ECODE_ADE :
                 exc_flags[EXC_INE]     ? ECODE_INE :
                 exc_flags[EXC_SYS]     ? ECODE_SYS :
                 exc_flags[EXC_BRK]     ? ECODE_BRK :
                 exc_flags[EXC_ALE]     ? ECODE_ALE : 6'h0;
      esubcode = (!has_int && exc_flags[EXC_ADEF]) ? ESUBCODE_ADEF : 9'h0;
   end
endmodule

// File: rtl/wb_exc_commit.sv
// wb_exc_commit: WB-stage commit, exception/ERTN event generation and front-end redirect handshake.
// Optional debug trace ports are enabled by defining WB_DEBUG_TRACE_EN.
module wb_exc_commit
   import wb_exc_commit_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_pc,
   input  logic [4:0]              in_exc,
   input  logic [31:0]             in_vaddr,
   input  logic                    in_ertn,
   input  logic [CSR_CTRL_LEN-1:0] in_csr,
   input  logic                    in_rf_we,
   input  logic [4:0]              in_rf_waddr,
   input  logic [31:0]             in_rf_wdata,
   input  logic                    has_int,
   input  logic [31:0]             csr_rvalue,
   input  logic [31:0]             ex_entry,
   input  logic [31:0]             era_pc,
   output logic [CSR_CTRL_LEN-1:0] csr_ctrl,
   output logic                    csr_valid,
   output logic [WB2CSR_LEN-1:0]   csr_in_bus,
   output logic                    rf_we,
   output logic [4:0]              rf_waddr,
   output logic [31:0]             rf_wdata,
   output logic                    flush,
   output logic [31:0]             flush_target,
   input  logic                    flush_ack
`ifdef WB_DEBUG_TRACE_EN
   ,
   output logic [31:0]             debug_wb_pc,
   output logic [3:0]              debug_wb_rf_we,
   output logic [4:0]              debug_wb_rf_wnum,
   output logic [31:0]             debug_wb_rf_wdata
`endif
);
   state_t                  state;
   logic                    wb_valid, wb_ertn, wb_rf_we;
   logic [31:0]             wb_pc, wb_vaddr, wb_wdata;
   logic [4:0]              wb_exc, wb_waddr;
   logic [CSR_CTRL_LEN-1:0] wb_csr;
   logic                    vld, enc_exc, exc, ertn_flush;
   logic [5:0]              ecode;
   logic [8:0]              esubcode;

   exc_prio_enc u_enc (
      .has_int  (has_int && vld),
      .exc_flags(wb_exc),
      .exc      (enc_exc),
      .ecode    (ecode),
      .esubcode (esubcode)
   );

   // outputs are forced quiet while reset is held, even if a stale entry sits in WB
   always_comb begin
      vld        = wb_valid && !reset;
      exc        = vld && enc_exc;
      ertn_flush = vld && wb_ertn && !exc;
      in_ready   = 1'b1;
      csr_valid  = vld && !exc;
      csr_ctrl   = csr_valid ? wb_csr : '0;
      csr_in_bus = {ertn_flush, exc, exc ? ecode : 6'h0, exc ? esubcode : 9'h0,
                    exc ? wb_pc : 32'h0, (exc && ecode == ECODE_ALE) ? wb_vaddr : 32'h0};
      rf_we      = vld && wb_rf_we && !exc;
      rf_waddr   = wb_waddr;
      rf_wdata   = wb_csr[CSR_RE_BIT] ? csr_rvalue : wb_wdata;
   end

`ifdef WB_DEBUG_TRACE_EN
   always_comb begin
      debug_wb_pc       = vld ? wb_pc : 32'h0;
      debug_wb_rf_we    = {4{rf_we}};
      debug_wb_rf_wnum  = vld ? wb_waddr : 5'h0;
      debug_wb_rf_wdata = vld ? rf_wdata : 32'h0;
   end
`endif

   always_ff @(posedge clk) begin
      if (in_valid) begin
         wb_pc    <= in_pc;
         wb_exc   <= in_exc;
         wb_vaddr <= in_vaddr;
         wb_ertn  <= in_ertn;
         wb_csr   <= in_csr;
         wb_rf_we <= in_rf_we;
         wb_waddr <= in_rf_waddr;
         wb_wdata <= in_rf_wdata;
      end
   end

   // anything arriving in the event cycle or while a redirect is pending is younger than the flush
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid     <= 1'b0;
         state        <= S_RUN;
         flush        <= 1'b0;
         flush_target <= 32'h0;
      end else begin
         wb_valid <= in_valid && in_ready && state == S_RUN && !(exc || ertn_flush);
         if (state == S_RUN && (exc || ertn_flush)) begin
            state        <= S_FLUSH_WAIT;
            flush        <= 1'b1;
            flush_target <= exc ? ex_entry : era_pc;
         end else if (state == S_FLUSH_WAIT && flush_ack) begin
            state <= S_RUN;
            flush <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_wb_exc_commit.sv
// tb_wb_exc_commit: table-driven directed checks of commit, cause priority and the flush handshake
module tb_wb_exc_commit;
   import wb_exc_commit_pkg::*;
   logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready;
   logic [31:0] in_pc = '0, in_vaddr = '0, in_rf_wdata = '0, csr_rvalue = '0;
   logic [4:0]  in_exc = '0, in_rf_waddr = '0, rf_waddr;
   logic        in_ertn = 1'b0, in_rf_we = 1'b0, has_int = 1'b0, flush_ack = 1'b0;
   logic [79:0] in_csr = '0, csr_ctrl;
   logic [31:0] ex_entry = 32'h1c008000, era_pc = 32'h1c000200;
   logic        csr_valid, rf_we, flush;
   logic [80:0] csr_in_bus;
   logic [31:0] rf_wdata, flush_target;
   int errs = 0, checks = 0;

   wb_exc_commit dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_exc(in_exc), .in_vaddr(in_vaddr), .in_ertn(in_ertn), .in_csr(in_csr),
      .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_rf_wdata(in_rf_wdata),
      .has_int(has_int), .csr_rvalue(csr_rvalue), .ex_entry(ex_entry), .era_pc(era_pc),
      .csr_ctrl(csr_ctrl), .csr_valid(csr_valid), .csr_in_bus(csr_in_bus), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flush(flush), .flush_target(flush_target),
      .flush_ack(flush_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc; logic [4:0] exc; logic [31:0] vaddr; logic ertn; logic [79:0] csr;
      logic rfwe; logic [4:0] waddr; logic [31:0] wdata; logic hint; logic [31:0] rval;
      logic e_csrv; logic e_rfwe; logic [31:0] e_wdata; logic [80:0] e_bus;
      logic e_flush; logic [31:0] e_tgt;
   } vec_t;
   vec_t v[10];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [80:0] mk_bus(logic er, logic ex, logic [5:0] ec, logic [31:0] pc, logic [31:0] va);
      return {er, ex, ec, 9'h0, pc, va};
   endfunction

   function automatic logic [79:0] mk_csr(logic [13:0] num, logic re, logic we, logic [31:0] wv, logic [31:0] wm);
      return {num, re, we, wv, wm};
   endfunction

   function automatic vec_t mk(logic [31:0] pc, logic [4:0] exc, logic [31:0] va, logic er, logic [79:0] csr,
                               logic rfwe, logic [4:0] wa, logic [31:0] wd, logic hint, logic [31:0] rv,
                               logic ecv, logic erf, logic [31:0] ewd, logic [80:0] ebus, logic efl, logic [31:0] etg);
      vec_t x;
      x.pc = pc; x.exc = exc; x.vaddr = va; x.ertn = er; x.csr = csr; x.rfwe = rfwe; x.waddr = wa;
      x.wdata = wd; x.hint = hint; x.rval = rv; x.e_csrv = ecv; x.e_rfwe = erf; x.e_wdata = ewd;
      x.e_bus = ebus; x.e_flush = efl; x.e_tgt = etg;
      return x;
   endfunction

   task automatic plain(input logic [4:0] wa, input logic [31:0] wd);
      in_valid = 1'b1; in_exc = '0; in_ertn = 1'b0; in_csr = '0; in_rf_we = 1'b1;
      in_rf_waddr = wa; in_rf_wdata = wd;
   endtask

   initial begin
      v[0] = mk(32'h1c000000, 5'b00000, 0, 0, mk_csr(14'h30, 0, 1, 32'h1234, 32'hffffffff), 0, 0, 0, 0, 0,
                1, 0, 0, '0, 0, 0);
      v[1] = mk(32'h1c000100, 5'b00100, 0, 0, '0, 1, 3, 32'h11, 0, 0,
                0, 0, 0, mk_bus(0, 1, 6'hB, 32'h1c000100, 0), 1, 32'h1c008000);
      v[2] = mk(32'h1c000104, 5'b00001, 3, 0, '0, 1, 3, 32'h22, 1, 0,
                0, 0, 0, mk_bus(0, 1, 6'h0, 32'h1c000104, 0), 1, 32'h1c008000);
      v[3] = mk(32'h1c000108, 5'b00001, 3, 0, '0, 0, 0, 0, 0, 0,
                0, 0, 0, mk_bus(0, 1, 6'h9, 32'h1c000108, 3), 1, 32'h1c008000);
      v[4] = mk(32'h1c00010c, 5'b00000, 0, 1, '0, 0, 0, 0, 0, 0,
                1, 0, 0, mk_bus(1, 0, 0, 0, 0), 1, 32'h1c000200);
      v[5] = mk(32'h1c000110, 5'b00000, 0, 0, mk_csr(14'h5, 1, 0, 0, 0), 1, 4, 32'h55, 0, 32'habcd,
                1, 1, 32'habcd, '0, 0, 0);
      v[6] = mk(32'h1c000114, 5'b01000, 0, 1, '0, 0, 0, 0, 0, 0,
                0, 0, 0, mk_bus(0, 1, 6'hD, 32'h1c000114, 0), 1, 32'h1c008000);
      v[7] = mk(32'h1c000118, 5'b10010, 7, 0, '0, 0, 0, 0, 0, 0,
                0, 0, 0, mk_bus(0, 1, 6'h8, 32'h1c000118, 0), 1, 32'h1c008000);
      v[8] = mk(32'h1c00011c, 5'b00011, 9, 0, '0, 0, 0, 0, 0, 0,
                0, 0, 0, mk_bus(0, 1, 6'hC, 32'h1c00011c, 0), 1, 32'h1c008000);
      v[9] = mk(32'h1c000120, 5'b00000, 0, 0, '0, 1, 7, 32'h77, 0, 32'hdead,
                1, 1, 32'h77, '0, 0, 0);

      tick; tick;
      chk("rst_flush", flush, 0);
      chk("rst_target", flush_target, 0);
      chk("rst_bus", csr_in_bus, 0);
      chk("rst_csrv", csr_valid, 0);
      chk("rst_ctrl", csr_ctrl, 0);
      chk("rst_rfwe", rf_we, 0);
      reset = 1'b0;
      has_int = 1'b1; flush_ack = 1'b1;
      #1;
      chk("idle_int_bus", csr_in_bus, 0);
      tick;
      has_int = 1'b0; flush_ack = 1'b0;
      chk("idle_flush", flush, 0);

      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_pc = v[i].pc; in_exc = v[i].exc; in_vaddr = v[i].vaddr; in_ertn = v[i].ertn;
         in_csr = v[i].csr; in_rf_we = v[i].rfwe; in_rf_waddr = v[i].waddr; in_rf_wdata = v[i].wdata;
         tick;
         in_valid = 1'b0; has_int = v[i].hint; csr_rvalue = v[i].rval;
         #1;
         chk($sformatf("v%0d_csrv", i), csr_valid, v[i].e_csrv);
         chk($sformatf("v%0d_ctrl", i), csr_ctrl, v[i].e_csrv ? v[i].csr : 80'h0);
         chk($sformatf("v%0d_bus", i), csr_in_bus, v[i].e_bus);
         chk($sformatf("v%0d_rfwe", i), rf_we, v[i].e_rfwe);
         if (v[i].e_rfwe) begin
            chk($sformatf("v%0d_wdata", i), rf_wdata, v[i].e_wdata);
            chk($sformatf("v%0d_waddr", i), rf_waddr, v[i].waddr);
         end
         tick;
         has_int = 1'b0;
         chk($sformatf("v%0d_pulse", i), csr_in_bus, 0);
         chk($sformatf("v%0d_flush", i), flush, v[i].e_flush);
         if (v[i].e_flush) begin
            chk($sformatf("v%0d_tgt", i), flush_target, v[i].e_tgt);
            tick;
            chk($sformatf("v%0d_hold", i), flush, 1);
            chk($sformatf("v%0d_hold_tgt", i), flush_target, v[i].e_tgt);
            flush_ack = 1'b1;
            tick;
            flush_ack = 1'b0;
            chk($sformatf("v%0d_unflush", i), flush, 0);
         end
      end

      // ERTN, then three instructions and one more on the ack cycle must all be dropped
      in_valid = 1'b1; in_exc = '0; in_ertn = 1'b1; in_csr = '0; in_rf_we = 1'b0; in_pc = 32'h1c000300;
      tick;
      in_valid = 1'b0;
      chk("drain_ertn", csr_in_bus[80], 1);
      plain(5'd9, 32'h99);
      tick;
      chk("drain_flush", flush, 1);
      chk("drain_tgt", flush_target, 32'h1c000200);
      for (int k = 0; k < 3; k++) begin
         tick;
         chk($sformatf("drain%0d_rfwe", k), rf_we, 0);
         chk($sformatf("drain%0d_csrv", k), csr_valid, 0);
      end
      flush_ack = 1'b1;
      tick;
      flush_ack = 1'b0; in_valid = 1'b0;
      chk("drain_unflush", flush, 0);
      chk("drain_ack_rfwe", rf_we, 0);
      plain(5'd10, 32'haa);
      tick;
      in_valid = 1'b0;
      chk("drain_after_rfwe", rf_we, 1);
      chk("drain_after_wdata", rf_wdata, 32'haa);

      // reset in the middle of FLUSH_WAIT
      tick;
      in_valid = 1'b1; in_exc = 5'b00100; in_rf_we = 1'b0; in_pc = 32'h1c000400;
      tick;
      in_valid = 1'b0;
      tick;
      chk("mid_flush", flush, 1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("mid_rst_flush", flush, 0);
      chk("mid_rst_tgt", flush_target, 0);
      chk("mid_rst_bus", csr_in_bus, 0);
      plain(5'd12, 32'hcc);
      tick;
      in_valid = 1'b0;
      chk("mid_rst_rfwe", rf_we, 1);
      chk("mid_rst_wdata", rf_wdata, 32'hcc);
      tick;
      chk("mid_rst_noflush", flush, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/wb_exc_commit.md
Name: wb_exc_commit

Overview:
- Writeback-stage commit and exception unit.
- It is the producer side of the CSR file's instruction interface and its writeback-to-CSR event bus.
- It registers instructions retiring from MEM, prioritises their exception flags together with the pending interrupt, and emits a single-cycle exception/ERTN event to the CSR file. Otherwise it issues the CSR read/write request and the register-file write.
- On an exception or ERTN it redirects the front end, then drains until that redirect is acknowledged.

Parameters:
- WB2CSR_LEN, 81, width of csr_in_bus: {ertn_flush, wb_ex, ecode[5:0], esubcode[8:0], pc[31:0], vaddr[31:0]}.
- CSR_CTRL_LEN, 80, width of csr_ctrl: {csr_num[13:0], re, we, wvalue[31:0], wmask[31:0]}.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  MEM→WB instruction valid.
- in_ready  out  1  WB can accept an instruction.
- in_pc  in  32  instruction PC.
- in_exc  in  5  {adef, ine, sys, brk, ale} flags raised upstream.
- in_vaddr  in  32  data address, for ALE.
- in_ertn  in  1  instruction is ERTN.
- in_csr  in  80  csr_ctrl fields for this instruction.
- in_rf_we  in  1  register write enable.
- in_rf_waddr  in  5  register write address.
- in_rf_wdata  in  32  register write data.
- has_int  in  1  pending enabled interrupt, from the CSR file.
- csr_rvalue  in  32  CSR read data.
- ex_entry  in  32  exception vector.
- era_pc  in  32  ERTN return address.
- csr_ctrl  out  80  CSR request.
- csr_valid  out  1  CSR request valid.
- csr_in_bus  out  81  event bus to the CSR file.
- rf_we  out  1  register write enable.
- rf_waddr  out  5  register write address.
- rf_wdata  out  32  register write data.
- flush  out  1  pipeline flush and redirect request.
- flush_target  out  32  redirect PC.
- flush_ack  in  1  front end has taken the redirect.

Behaviour:
- Single WB register holding valid plus all in_* fields.
- Load rule: loads when in_valid && in_ready. in_ready = 1 in RUN; in FLUSH_WAIT it is also 1 but loaded data is discarded (valid forced 0).
- Commit: a valid WB entry commits in the cycle after it loads; there are no WB stalls.
- Cause priority, highest first:
  - has_int: ecode 0x0.
  - adef: ecode 0x8, esubcode 0.
  - ine: ecode 0xD.
  - sys: ecode 0xB.
  - brk: ecode 0xC.
  - ale: ecode 0x9.
- Unused fields:
  - esubcode = 0 for all causes.
  - vaddr = WB vaddr for ale, else 0.
  - pc = WB pc.
- Interrupt sampling: has_int is sampled only in a cycle with a valid WB entry. The interrupt is attached to that instruction, which then does not execute.
- Commit-cycle outputs:
  - exc = valid && (has_int || |exc).
  - wb_ex = exc.
  - ertn_flush = valid && ertn && !exc.
  - csr_valid = valid && !exc; csr_ctrl passes through whenever csr_valid = 1, else 0.
  - rf_we = valid && in_rf_we && !exc.
  - rf_wdata = csr_rvalue if csr re, else the stored wdata.
- Event pulse: wb_ex and ertn_flush are each high for exactly one cycle per event.
- FSM:
  - RUN → FLUSH_WAIT on wb_ex or ertn_flush.
  - In that cycle flush_target is latched: ex_entry if wb_ex, else era_pc.
  - FLUSH_WAIT holds flush = 1 and flush_target stable until flush_ack.
  - On flush_ack: → RUN, flush = 0 the next cycle.
  - Incoming instructions are discarded up to and including the cycle of flush_ack.
- flush_ack in RUN is ignored.
- Reset, any cycle including mid-FLUSH_WAIT:
  - State RUN, WB valid 0.
  - flush = 0, flush_target = 0.
  - csr_in_bus = 0, csr_valid = 0, csr_ctrl = 0.
  - rf_we = 0.
- Simultaneous ertn with an exception flag or interrupt: the exception wins and ertn_flush = 0.

Optional Feature:
- Macro WB_DEBUG_TRACE_EN.
- Defined: adds outputs debug_wb_pc[31:0], debug_wb_rf_we[3:0] (rf_we replicated), debug_wb_rf_wnum[4:0] and debug_wb_rf_wdata[31:0], all driven from the commit cycle; 0 in reset.
- Undefined: these ports do not exist, with no logic change.

Decomposition:
- Shared package/header carries:
  - ECODE_INT/ADE/ALE/SYS/BRK/INE and ESUBCODE_ADEF.
  - WB2CSR_LEN and CSR_CTRL_LEN.
  - csr_ctrl field offsets.
  - FSM state encodings.
- One sub-module, exc_prio_enc: combinational cause encoder, {has_int, in_exc} → {exc, ecode, esubcode}.

Test Plan:
- csrwr: csr_num 0x30, wvalue 0x1234, wmask 0xFFFFFFFF, no flags → csr_valid = 1 for one cycle with matching csr_ctrl; no flush; csr_in_bus = 0.
- sys at pc 0x1c000100, ex_entry 0x1c008000 → one cycle wb_ex = 1, ecode 0xB, pc 0x1c000100; csr_valid = 0; rf_we = 0; flush = 1, target 0x1c008000, held until flush_ack.
- ale with vaddr 0x3 plus has_int = 1 → ecode 0x0, vaddr field 0; interrupt wins.
- ertn, era_pc 0x1c000200 → ertn_flush = 1 for one cycle, target 0x1c000200. Three in_valid instructions during FLUSH_WAIT → none commit, rf_we stays 0.
- csrrd with csr_rvalue 0xABCD and rf_waddr 4 → rf_we = 1, rf_wdata 0xABCD.
- reset asserted in FLUSH_WAIT → next cycle flush = 0, state RUN; the next instruction commits normally.
